// File: rtl/mem_stage_sbuf.sv
// -----------------------------------------------------------------------------
// mem_stage_sbuf
//   MEM-stage data-memory front end: DEPTH-entry posted store buffer with byte
//   coalescing, store-to-load forwarding, byte-enable generation, load
//   extension and a req/ack handshake to a multi-cycle data memory.
//
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   valid_M, we_M       memory op present in MEM; 1 = store, 0 = load
//   size_M, sext_M      00 byte / 01 half / 1x word; sign-extend load result
//   addr_M, wdata_M     byte address; right-aligned store data
//   stall_M             freeze IF..MEM this cycle (combinational)
//   rdata_M             extended load result (valid when load & !stall_M)
//   misalign_M          address not aligned to size (combinational)
//   sb_empty            store buffer empty, no drain in flight
//   dm_req/we/addr/be/wdata   registered request to data memory
//   dm_rdata, dm_ack    memory read word and transfer-complete
// -----------------------------------------------------------------------------
module mem_stage_sbuf #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_M,
    input  logic              we_M,
    input  logic [1:0]        size_M,
    input  logic              sext_M,
    input  logic [ADDR_W-1:0] addr_M,
    input  logic [31:0]       wdata_M,
    output logic              stall_M,
    output logic [31:0]       rdata_M,
    output logic              misalign_M,
    output logic              sb_empty,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [3:0]        dm_be,
    output logic [31:0]       dm_wdata,
    input  logic [31:0]       dm_rdata,
    input  logic              dm_ack
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned WA_W  = ADDR_W - 2;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_LDONE = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    // Store buffer storage
    logic [WA_W-1:0]  r_addr [DEPTH];
    logic [3:0]       r_be   [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             r_sb_empty;

    state_t           r_state;
    logic [31:0]      r_rd_q;

    logic [WA_W-1:0]  w_waddr;
    logic [3:0]       w_be;
    logic [31:0]      w_lane;
    logic             w_misal;
    logic [PTR_W-1:0] w_young;
    logic             w_full;
    logic             w_merge;
    logic             w_merge_head;
    logic             w_st_acc;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_count_nxt;
    logic [31:0]      w_merged;
    logic [3:0]       w_head_be;
    logic [31:0]      w_head_data;
    logic [3:0]       w_fwd_cov;
    logic [31:0]      w_fwd_word;
    logic             w_ld;
    logic             w_ld_hit;
    logic             w_ld_nomatch;

    // Expand byte enables to a 32-bit lane mask
    function automatic logic [31:0] f_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    // Select the addressed byte/half of a word and extend it
    function automatic logic [31:0] f_extend(input logic [31:0] w, input logic [1:0] sz,
                                             input logic [1:0] a, input logic sx);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(w >> {a, 3'b000});
        h = a[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   r = sx ? {{24{b[7]}}, b} : {24'h0, b};
            2'b01:   r = sx ? {{16{h[15]}}, h} : {16'h0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    assign w_waddr = addr_M[ADDR_W-1:2];

    // Byte enables and lane-aligned store data; misaligned low bits are ignored
    always_comb begin
        w_be    = 4'b1111;
        w_lane  = wdata_M;
        w_misal = 1'b0;
        case (size_M)
            2'b00: begin
                w_be   = 4'(4'b0001 << addr_M[1:0]);
                w_lane = 32'(wdata_M[7:0]) << {addr_M[1:0], 3'b000};
            end
            2'b01: begin
                w_be    = addr_M[1] ? 4'b1100 : 4'b0011;
                w_lane  = addr_M[1] ? {wdata_M[15:0], 16'h0} : {16'h0, wdata_M[15:0]};
                w_misal = addr_M[0];
            end
            default: begin
                w_misal = |addr_M[1:0];
            end
        endcase
    end

    assign misalign_M = valid_M & w_misal;

    // Coalescing: youngest entry may absorb the store unless it is being written out
    assign w_young      = r_tail - PTR_W'(1);
    assign w_full       = (r_count == CNT_FULL);
    assign w_merge      = valid_M & we_M & (r_count != '0) & (r_addr[w_young] == w_waddr)
                          & ~((r_state == S_DRAIN) & (w_young == r_head));
    assign w_st_acc     = valid_M & we_M & ~(w_full & ~w_merge);
    assign w_push       = w_st_acc & ~w_merge;
    assign w_pop        = (r_state == S_DRAIN) & dm_ack;
    assign w_count_nxt  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_merged     = (r_data[w_young] & ~f_mask(w_be)) | w_lane;

    // Head contents including a same-cycle merge, so a drain launched now sees it
    assign w_merge_head = w_st_acc & w_merge & (w_young == r_head);
    assign w_head_be    = r_be[r_head] | (w_merge_head ? w_be : 4'b0000);
    assign w_head_data  = w_merge_head ? w_merged : r_data[r_head];

    // Forwarding: walk oldest to youngest so the youngest writer of each byte wins
    always_comb begin
        logic [PTR_W-1:0] v_idx;
        v_idx      = '0;
        w_fwd_cov  = 4'b0000;
        w_fwd_word = 32'h0;
        for (int k = 0; k < DEPTH; k++) begin
            v_idx = r_head + PTR_W'(k);
            if ((CNT_W'(k) < r_count) && (r_addr[v_idx] == w_waddr)) begin
                for (int l = 0; l < 4; l++) begin
                    if (r_be[v_idx][l]) begin
                        w_fwd_cov[l]        = 1'b1;
                        w_fwd_word[8*l +: 8] = r_data[v_idx][8*l +: 8];
                    end
                end
            end
        end
    end

    assign w_ld         = valid_M & ~we_M;
    assign w_ld_hit     = ((w_fwd_cov & w_be) == w_be);
    assign w_ld_nomatch = w_ld & ((w_fwd_cov & w_be) == 4'b0000);

    // Pipeline stall: full buffer for stores; anything but a forward hit for loads
    always_comb begin
        stall_M = 1'b0;
        if (valid_M) begin
            if (we_M) begin
                stall_M = w_full & ~w_merge;
            end else if (r_state != S_LDONE) begin
                stall_M = ~w_ld_hit;
            end
        end
    end

    assign rdata_M  = (r_state == S_LDONE) ? r_rd_q
                                           : f_extend(w_fwd_word, size_M, addr_M[1:0], sext_M);
    assign sb_empty = r_sb_empty;

    // Store buffer push / merge / pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_be[i]   <= 4'b0000;
                r_data[i] <= 32'h0;
            end
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_sb_empty <= 1'b1;
        end else begin
            if (w_st_acc) begin
                if (w_merge) begin
                    r_be[w_young]   <= r_be[w_young] | w_be;
                    r_data[w_young] <= w_merged;
                end else begin
                    r_addr[r_tail] <= w_waddr;
                    r_be[r_tail]   <= w_be;
                    r_data[r_tail] <= w_lane;
                    r_tail         <= r_tail + PTR_W'(1);
                end
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            r_count    <= w_count_nxt;
            r_sb_empty <= (w_count_nxt == '0);
        end
    end

    // Memory-side FSM; dm_* registered and only updated on state entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_rd_q   <= 32'h0;
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_addr  <= '0;
            dm_be    <= 4'b0000;
            dm_wdata <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_ld_nomatch && !w_full) begin
                        r_state <= S_LOAD;
                        dm_req  <= 1'b1;
                        dm_we   <= 1'b0;
                        dm_addr <= {w_waddr, 2'b00};
                        dm_be   <= w_be;
                    end else if (r_count != '0) begin
                        r_state  <= S_DRAIN;
                        dm_req   <= 1'b1;
                        dm_we    <= 1'b1;
                        dm_addr  <= {r_addr[r_head], 2'b00};
                        dm_be    <= w_head_be;
                        dm_wdata <= w_head_data;
                    end
                end
                S_LOAD: begin
                    if (dm_ack) begin
                        r_state <= S_LDONE;
                        r_rd_q  <= f_extend(dm_rdata, size_M, addr_M[1:0], sext_M);
                        dm_req  <= 1'b0;
                    end
                end
                S_LDONE: begin
                    r_state <= S_IDLE;
                end
                S_DRAIN: begin
                    if (dm_ack) begin
                        r_state <= S_IDLE;
                        dm_req  <= 1'b0;
                        dm_we   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_stage_sbuf.md
# mem_stage_sbuf

Parametrised MEM-stage data-memory front end for the pipelined MIPS core. It replaces the single-cycle byte-enable/data-memory path with three parts: a DEPTH-entry posted store buffer with byte coalescing, store-to-load forwarding, and a req/ack handshake to a multi-cycle data memory. It generates byte enables for sb/sh/sw, extends lb/lbu/lh/lhu/lw results, and stalls the pipeline when a store or load cannot complete.

## Interface
- ADDR_W, 32, byte-address width; data width is fixed at 32.
- DEPTH, 4, store-buffer entries (≥2, power of two).
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- valid_M  in  1  memory instruction present in MEM.
- we_M  in  1  1 = store, 0 = load.
- size_M  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- sext_M  in  1  sign-extend load result (lb/lh).
- addr_M  in  ADDR_W  byte address (ALU result).
- wdata_M  in  32  store data, already forwarded, right-aligned.
- stall_M  out  1  freeze IF..MEM this cycle (combinational).
- rdata_M  out  32  extended load result; valid when valid_M & !we_M & !stall_M.
- misalign_M  out  1  valid_M & address not aligned to size (combinational).
- sb_empty  out  1  buffer empty and no drain in flight.
- dm_req  out  1  memory request, held until ack.
- dm_we  out  1  write request.
- dm_addr  out  ADDR_W  word-aligned address (low 2 bits 0).
- dm_be  out  4  byte enables.
- dm_wdata  out  32  lane-aligned write data.
- dm_rdata  in  32  read word, valid with dm_ack.
- dm_ack  in  1  transfer complete; may be asserted in the same cycle as dm_req.

## Operation
- Lane mapping: the byte at addr[1:0]=k uses lane k (bits 8k+7:8k). Half: be=0011 or 1100 by addr[1]. Word: be=1111. Misaligned low bits are forced aligned (half clears addr[0]; word clears addr[1:0]) and misalign_M=1.
- Entry = {word addr, be[3:0], data[31:0]}. FIFO order: head drains first.
- Store acceptance (valid_M & we_M & !stall_M):
  - Merge into the youngest entry if the word address matches and that entry is not the in-flight head. New bytes overwrite old ones and be ORs.
  - Otherwise push.
  - stall_M=1 if count==DEPTH and no merge is possible.
- Load lookup: all entries are compared on word address. Per needed byte, the youngest matching entry wins.
  - All needed bytes covered → forward hit: rdata_M in the same cycle, stall_M=0, no memory access.
  - Some but not all covered → partial: stall_M=1, re-evaluated every cycle while draining proceeds.
  - No match → memory read.
- Extension: the selected byte/half is sign- or zero-extended per sext_M; words pass through.
- FSM:
  - IDLE → LOAD when a no-match load is present and count<DEPTH.
  - IDLE → DRAIN when count>0 and (no load is waiting, or count==DEPTH).
  - LOAD: dm_req=1, dm_we=0. On ack, capture the extended result in rd_q → LDONE.
  - LDONE: stall_M=0, rdata_M=rd_q, one cycle → IDLE.
  - DRAIN: dm_req=1, dm_we=1 with head fields. On ack, pop head → IDLE.
- A no-match load present outside LDONE forces stall_M=1.
- Reset (asynchronous, any time): count=0, pointers 0, FSM=IDLE, dm_req=0, dm_we=0, dm_addr=0, dm_be=0, dm_wdata=0, rd_q=0, sb_empty=1. An in-flight transaction is abandoned.

## Timing
- Forward hit and merge/push: 0 added cycles.
- Memory load: detect in cycle N (stall); dm_req from N+1. With ack at N+k, LDONE is cycle N+k+1 and the instruction leaves MEM at the end of that cycle. Same-cycle ack gives a 2-cycle stall.
- Drain: head write lasts from dm_req to ack, minimum 1 cycle. The slot is freed at the ack edge, so a stalled store at full is accepted the following cycle, not in the ack cycle.
- dm_* outputs are registered, change only on state entry, and hold stable while dm_req=1 & !dm_ack.
- Simultaneous pop and push in one cycle is legal when count<DEPTH; count is unchanged.
- Pointers wrap modulo DEPTH.

## Test plan
- sw 0x11223344 to 0x100, then lb from 0x101 (sext) → forward hit, rdata_M=0x00000033, no dm_req, stall_M=0.
- sb 0xAA to 0x200, then sb 0xBB to 0x203 → one entry, be=1001. Drain: dm_addr=0x200, dm_be=1001, dm_wdata=0xBB0000AA.
- With dm_ack delayed 3 cycles, push 5 stores to distinct words at DEPTH=4 → 5th store stalls until the first ack and is accepted the cycle after it.
- sh 0x8001 to 0x300, then lw 0x300 (partial) → stall until drained, then read. Memory returns 0x12348001; rdata_M matches.
- lh from 0x402 with dm_rdata=0xF00D0000 → rdata_M=0xFFFFF00D. Same with lhu → 0x0000F00D. Two stall cycles with same-cycle ack.
- Assert reset low mid-DRAIN → dm_req drops immediately; count=0 and sb_empty=1 after release.
